// File: rtl/ram_pkg.sv
// Shared definitions for the DRAM refresh logic: refresh FSM states and the
// default timing constants used by the RAM controller and its bench.
package ram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      URG  = 2'd2,
      GAP  = 2'd3
   } ref_state_e;

   localparam int REF_INTERVAL = 375;
   localparam int REF_URG_AGE  = 64;
   localparam int REF_DEBT_MAX = 3;

endpackage

// File: rtl/ref_interval_ctr.sv
// Free-running refresh interval counter; tick_o marks the last cycle of each
// interval. Dropping en_i parks the counter at zero so re-enabling restarts it.
module ref_interval_ctr
   import ram_pkg::*;
#(
   parameter int INTERVAL = REF_INTERVAL
) (
   input  logic CLK,
   input  logic nRESET,
   input  logic en_i,
   output logic tick_o
);

   localparam int ICW = $clog2(INTERVAL);
   localparam logic [ICW-1:0] IC_LAST = ICW'(INTERVAL - 1);

   logic [ICW-1:0] ic_q;
   logic [ICW-1:0] ic_d;

   assign tick_o = en_i && (ic_q == IC_LAST);

   always_comb begin
      ic_d = '0;
      if (en_i && (ic_q != IC_LAST)) begin
         ic_d = ic_q + ICW'(1);
      end else begin
         ic_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         ic_q <= '0;
      end else begin
         ic_q <= ic_d;
      end
   end

endmodule

// File: rtl/ram_refresh_timer.sv
// DRAM refresh request generator: tracks refresh debt and request age and
// drives registered RefReq/RefUrg with a one-cycle low gap after every ack.
module ram_refresh_timer
   import ram_pkg::*;
#(
   parameter int INTERVAL = REF_INTERVAL,
   parameter int URG_AGE  = REF_URG_AGE,
   parameter int DEBT_MAX = REF_DEBT_MAX
) (
   input  logic CLK,
   input  logic nRESET,
   input  logic RefEn,
   input  logic RefAck,
   output logic RefReq,
   output logic RefUrg,
   output logic RefMiss
);

   localparam int DW = $clog2(DEBT_MAX + 1);
   localparam int AW = $clog2(URG_AGE + 1);
   localparam logic [DW-1:0] D_MAX = DW'(DEBT_MAX);
   localparam logic [DW-1:0] D_TWO = DW'(2);
   localparam logic [AW-1:0] A_MAX = AW'(URG_AGE);

   ref_state_e     state_q, state_d;
   logic [DW-1:0]  debt_q, debt_d;
   logic [AW-1:0]  age_q, age_d;
   logic           miss_d;
   logic           req_d, urg_d;
   logic           tick_s;
   logic           ack_ok_s;

   ref_interval_ctr #(.INTERVAL(INTERVAL)) u_ic (
      .CLK    (CLK),
      .nRESET (nRESET),
      .en_i   (RefEn),
      .tick_o (tick_s)
   );

   assign ack_ok_s = RefAck && ((state_q == PEND) || (state_q == URG)) && (debt_q != '0);

   // A tick coinciding with a valid ack cancels out, so it never counts as a miss.
   always_comb begin
      debt_d = debt_q;
      miss_d = RefMiss;
      if (tick_s && !ack_ok_s) begin
         if (debt_q == D_MAX) begin
            miss_d = 1'b1;
         end else begin
            debt_d = debt_q + DW'(1);
         end
      end else if (ack_ok_s && !tick_s) begin
         debt_d = debt_q - DW'(1);
      end else begin
         debt_d = debt_q;
      end
   end

   always_comb begin
      age_d = age_q;
      if (ack_ok_s || (debt_q == '0)) begin
         age_d = '0;
      end else if (age_q != A_MAX) begin
         age_d = age_q + AW'(1);
      end else begin
         age_d = age_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = (debt_q != '0) ? PEND : IDLE;
         PEND: begin
            if (ack_ok_s) begin
               state_d = GAP;
            end else if ((age_q == A_MAX) || (debt_q >= D_TWO)) begin
               state_d = URG;
            end else begin
               state_d = PEND;
            end
         end
         URG:  state_d = ack_ok_s ? GAP : URG;
         GAP: begin
            if (debt_q == '0) begin
               state_d = IDLE;
            end else if (debt_q >= D_TWO) begin
               state_d = URG;
            end else begin
               state_d = PEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d = 1'b0;
      urg_d = 1'b0;
      case (state_d)
         PEND:    begin req_d = 1'b1; urg_d = 1'b0; end
         URG:     begin req_d = 1'b1; urg_d = 1'b1; end
         default: begin req_d = 1'b0; urg_d = 1'b0; end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= IDLE;
         debt_q  <= '0;
         age_q   <= '0;
         RefReq  <= 1'b0;
         RefUrg  <= 1'b0;
         RefMiss <= 1'b0;
      end else begin
         state_q <= state_d;
         debt_q  <= debt_d;
         age_q   <= age_d;
         RefReq  <= req_d;
         RefUrg  <= urg_d;
         RefMiss <= miss_d;
      end
   end

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Bench for ram_refresh_timer: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural refresh model.
module tb_ram_refresh_timer;

   localparam int P_INT  = 16;
   localparam int P_AGE  = 4;
   localparam int P_DMAX = 3;

   logic CLK = 1'b0;
   logic nRESET = 1'b0;
   logic RefEn = 1'b0;
   logic RefAck = 1'b0;
   logic RefReq, RefUrg, RefMiss;

   int n_total = 0;
   int n_pass  = 0;

   // model: requested/urgent/gap flags, debt and age as plain integers
   int m_run, m_debt, m_age;
   bit m_req, m_urg, m_gap, m_miss;

   ram_refresh_timer #(.INTERVAL(P_INT), .URG_AGE(P_AGE), .DEBT_MAX(P_DMAX)) dut (
      .CLK     (CLK),
      .nRESET  (nRESET),
      .RefEn   (RefEn),
      .RefAck  (RefAck),
      .RefReq  (RefReq),
      .RefUrg  (RefUrg),
      .RefMiss (RefMiss)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_step(input bit en, input bit ack, input bit rstn);
      bit tick, ok;
      int n_debt, n_age;
      if (!rstn) begin
         m_run = 0; m_debt = 0; m_age = 0;
         m_req = 0; m_urg = 0; m_gap = 0; m_miss = 0;
         return;
      end
      tick = en && ((m_run % P_INT) == P_INT - 1);
      ok   = ack && m_req && (m_debt > 0);
      n_debt = m_debt;
      if (tick && !ok) begin
         if (m_debt == P_DMAX) m_miss = 1;
         else n_debt = m_debt + 1;
      end else if (ok && !tick) begin
         n_debt = m_debt - 1;
      end
      n_age = (ok || m_debt == 0) ? 0 : ((m_age < P_AGE) ? m_age + 1 : m_age);
      if (ok) begin
         m_gap = 1; m_req = 0; m_urg = 0;
      end else if (m_gap) begin
         m_gap = 0; m_req = (m_debt > 0); m_urg = (m_debt >= 2);
      end else if (!m_req) begin
         m_req = (m_debt > 0); m_urg = 0;
      end else if (!m_urg) begin
         m_urg = (m_age == P_AGE) || (m_debt >= 2);
      end
      m_debt = n_debt;
      m_age  = n_age;
      m_run  = en ? m_run + 1 : 0;
   endtask

   task automatic cycle(input bit en, input bit ack, input bit rstn);
      RefEn = en; RefAck = ack; nRESET = rstn;
      model_step(en, ack, rstn);
      @(posedge CLK);
      #1;
      check("outs", {29'd0, RefReq, RefUrg, RefMiss}, {29'd0, m_req, m_urg, m_miss});
      if (RefUrg && !RefReq) check("urg_wo_req", 32'd1, 32'd0);
   endtask

   initial begin
      int first_req, first_urg, first_miss, urg_seen;
      #1;
      // reset then free-running schedule with no acks
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check("reset_outs", {29'd0, RefReq, RefUrg, RefMiss}, 32'd0);
      first_req = -1; first_urg = -1; first_miss = -1;
      for (int k = 0; k < 70; k++) begin
         cycle(1'b1, 1'b0, 1'b1);
         if (RefReq && first_req < 0)   first_req = k + 1;
         if (RefUrg && first_urg < 0)   first_urg = k + 1;
         if (RefMiss && first_miss < 0) first_miss = k + 1;
      end
      check("first_req",  first_req, 17);
      check("first_urg",  first_urg, 21);
      check("first_miss", first_miss, 64);
      check("urg_at_dmax", RefUrg, 1);
      // reset while urgent with full debt
      cycle(1'b1, 1'b0, 1'b0);
      check("rst_in_urg", {29'd0, RefReq, RefUrg, RefMiss}, 32'd0);

      // ack two cycles after the request rises
      for (int k = 0; k < 17; k++) cycle(1'b1, 1'b0, 1'b1);
      check("s2_req_up", RefReq, 1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      check("s2_req_dn", RefReq, 0);
      urg_seen = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 1'b0, 1'b1);
         urg_seen += RefUrg;
         check("s2_stays_low", RefReq, 0);
      end
      check("s2_no_urg", urg_seen, 0);

      // ack coinciding with a tick while debt is 1
      cycle(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 31; k++) cycle(1'b1, 1'b0, 1'b1);
      check("s4_req", RefReq, 1);
      cycle(1'b1, 1'b1, 1'b1);
      check("s4_gap", RefReq, 0);
      cycle(1'b1, 1'b0, 1'b1);
      check("s4_req_back", RefReq, 1);
      check("s4_pend", RefUrg, 0);
      check("s4_no_miss", RefMiss, 0);

      // two ticks then ack: gap, then back to plain pending
      cycle(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 33; k++) cycle(1'b1, 1'b0, 1'b1);
      check("s3_urg", RefUrg, 1);
      cycle(1'b1, 1'b1, 1'b1);
      check("s3_gap", RefReq, 0);
      cycle(1'b1, 1'b0, 1'b1);
      check("s3_req", RefReq, 1);
      check("s3_pend", RefUrg, 0);

      // spurious ack in idle and a long disabled stretch
      cycle(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) cycle(1'b0, (k == 10), 1'b1);
      check("en0_idle", {30'd0, RefReq, RefUrg}, 32'd0);
      first_req = -1;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 1'b1);
         if (RefReq && first_req < 0) first_req = k + 1;
      end
      check("en_restart", first_req, 17);

      // randomized traffic with varying ack pressure
      for (int blk = 0; blk < 20; blk++) begin
         int ack_den;
         ack_den = $urandom_range(2, 40);
         for (int k = 0; k < 200; k++) begin
            cycle($urandom_range(0, 15) != 0, $urandom_range(0, ack_den - 1) == 0,
                  $urandom_range(0, 399) != 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
